// File: rtl/alu_exec_if.sv
// ============================================================================
//  alu_exec_if : request/response bundle between operand fetch, alu_exec and writeback
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface alu_exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output in_valid, alucontrol, srca, srcb, shamt, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal, hi, lo
  );

  modport slave (
    input  in_valid, alucontrol, srca, srcb, shamt, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
//  alu_exec : single-cycle ALU ops plus iterative signed multiply into HI/LO
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_exec #(
  parameter int unsigned MUL_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);

  localparam int unsigned c_ITERS  = 32 / MUL_BITS;
  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_XOR  = 4'b0011;
  localparam logic [3:0] c_OP_SUB  = 4'b0110;
  localparam logic [3:0] c_OP_SLT  = 4'b0111;
  localparam logic [3:0] c_OP_NOR  = 4'b1000;
  localparam logic [3:0] c_OP_MULT = 4'b1001;
  localparam logic [3:0] c_OP_SLL  = 4'b1010;
  localparam logic [3:0] c_OP_SRL  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_result;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_zero;
  logic        r_ovf;
  logic        r_ill;
  logic [63:0] r_mcand;
  logic [63:0] r_prod;
  logic [31:0] r_mplier;
  logic        r_neg;
  logic [5:0]  r_cnt;

  logic        w_accept;
  logic        w_is_mult;
  logic        w_mul_last;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_alu;
  logic        w_ovf;
  logic        w_ill;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_step;
  logic [63:0] w_final;

  assign w_accept   = bus.in_valid && (r_state == S_IDLE);
  assign w_is_mult  = (bus.alucontrol == c_OP_MULT);
  // One extra MUL cycle after the last shift-add applies the sign and commits HI/LO
  assign w_mul_last = (r_cnt == 6'(c_ITERS));
  assign w_sum      = bus.srca + bus.srcb;
  assign w_diff     = bus.srca - bus.srcb;
  assign w_abs_a    = bus.srca[31] ? -bus.srca : bus.srca;
  assign w_abs_b    = bus.srcb[31] ? -bus.srcb : bus.srcb;
  assign w_final    = r_neg ? -r_prod : r_prod;

  always_comb begin
    w_alu = 32'd0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (bus.alucontrol)
      c_OP_AND:  w_alu = bus.srca & bus.srcb;
      c_OP_OR:   w_alu = bus.srca | bus.srcb;
      c_OP_XOR:  w_alu = bus.srca ^ bus.srcb;
      c_OP_NOR:  w_alu = ~(bus.srca | bus.srcb);
      c_OP_ADD: begin
        w_alu = w_sum;
        w_ovf = (bus.srca[31] == bus.srcb[31]) && (w_sum[31] != bus.srca[31]);
      end
      c_OP_SUB: begin
        w_alu = w_diff;
        w_ovf = (bus.srca[31] != bus.srcb[31]) && (w_diff[31] != bus.srca[31]);
      end
      c_OP_SLT:  w_alu = {31'd0, ($signed(bus.srca) < $signed(bus.srcb))};
      c_OP_SLL:  w_alu = bus.srcb << bus.shamt;
      c_OP_SRL:  w_alu = bus.srcb >> bus.shamt;
      c_OP_MULT: w_alu = 32'd0;
      default:   w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_step = r_prod;
    for (int unsigned j = 0; j < MUL_BITS; j++) begin
      if (r_mplier[j]) begin
        w_step = w_step + (r_mcand << j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_is_mult ? S_MUL : S_DONE;
      S_MUL:   if (w_mul_last) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_ill    <= 1'b0;
      r_mcand  <= 64'd0;
      r_prod   <= 64'd0;
      r_mplier <= 32'd0;
      r_neg    <= 1'b0;
      r_cnt    <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mult) begin
              r_mcand  <= {32'd0, w_abs_a};
              r_mplier <= w_abs_b;
              r_neg    <= bus.srca[31] ^ bus.srcb[31];
              r_prod   <= 64'd0;
              r_cnt    <= 6'd0;
            end else begin
              r_result <= w_alu;
              r_zero   <= (w_alu == 32'd0);
              r_ovf    <= w_ovf;
              r_ill    <= w_ill;
            end
          end
        end
        S_MUL: begin
          if (w_mul_last) begin
            r_hi     <= w_final[63:32];
            r_lo     <= w_final[31:0];
            r_result <= w_final[31:0];
            r_zero   <= (w_final[31:0] == 32'd0);
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
          end else begin
            r_prod   <= w_step;
            r_mcand  <= r_mcand << MUL_BITS;
            r_mplier <= r_mplier >> MUL_BITS;
            r_cnt    <= r_cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_ovf;
  assign bus.illegal   = r_ill;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
//  tb_alu_exec : directed self-checking bench for alu_exec
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_exec_if bus ();

  alu_exec #(.MUL_BITS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    bus.alucontrol = op;
    bus.srca       = a;
    bus.srcb       = b;
    bus.shamt      = sh;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("back_to_idle", bus.in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                        input logic eo, input logic ei);
    issue(op, a, b, sh);
    check({tag, "_valid"},    bus.out_valid, 1);
    check({tag, "_result"},   bus.result,    er);
    check({tag, "_zero"},     bus.zero,      (er == 32'd0));
    check({tag, "_overflow"}, bus.overflow,  eo);
    check({tag, "_illegal"},  bus.illegal,   ei);
    consume();
  endtask

  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
    int   lat;
    logic ready_seen;
    issue(4'b1001, a, b, 5'd0);
    lat        = 0;
    ready_seen = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"},  lat,        33);
    check({tag, "_in_ready"}, ready_seen, 0);
    check({tag, "_hi"},       bus.hi,     ehi);
    check({tag, "_lo"},       bus.lo,     elo);
    check({tag, "_result"},   bus.result, elo);
    consume();
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.alucontrol = 4'd0;
    bus.srca       = 32'd0;
    bus.srcb       = 32'd0;
    bus.shamt      = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result",    bus.result,    0);
    check("rst_zero",      bus.zero,      0);
    check("rst_hi",        bus.hi,        0);
    check("rst_lo",        bus.lo,        0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b1, 1'b0);
    run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0, 32'h0000_0000, 1'b0, 1'b0);
    run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001, 1'b0, 1'b0);
    run_op("nor", 4'b1000, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0);
    run_op("or",  4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b0, 1'b0);
    run_op("xor", 4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 1'b0, 1'b0);

    run_mult("mult_neg", 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_op("illegal", 4'b0100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 32'h0000_0000, 1'b0, 1'b1);
    check("illegal_hi_kept", bus.hi, 32'hFFFF_FFFF);
    check("illegal_lo_kept", bus.lo, 32'hFFFF_FFFA);
    run_op("sll", 4'b1010, 32'h0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    run_op("srl", 4'b1011, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0);

    run_mult("mult_min", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    // Backpressure: hold the result while a second request waits
    issue(4'b0010, 32'd2, 32'd3, 5'd0);
    @(negedge clk);
    bus.alucontrol = 4'b0110;
    bus.srca       = 32'd10;
    bus.srcb       = 32'd4;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid",    bus.out_valid, 1);
      check("bp_result",   bus.result,    32'd5);
      check("bp_in_ready", bus.in_ready,  0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_idle_ready", bus.in_ready,  1);
    check("bp_idle_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_next_valid",  bus.out_valid, 1);
    check("bp_next_result", bus.result,    32'd6);
    consume();

    // Asynchronous reset in the middle of a multiply
    issue(4'b1001, 32'd3, 32'd5, 5'd0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mul_out_valid", bus.out_valid, 0);
    check("rst_mul_in_ready",  bus.in_ready,  1);
    check("rst_mul_hi",        bus.hi,        0);
    check("rst_mul_lo",        bus.lo,        0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", bus.in_ready, 1);
    run_op("post_rst_add", 4'b0010, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1'b0);
    check("post_rst_hi", bus.hi, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
